// File: rtl/i2c_target_regs.sv
// i2c_target_regs
// ---------------
// I2C target (responder) that gives an external I2C controller byte-wide
// access to a 256-entry register space through a simple strobe bus. SCL and
// SDA are oversampled in clk_i. SCL is never stretched, and SDA is only ever
// driven low (open-drain) through sda_t_o.
//
// Ports
//   clk_i        block clock, at least 20x the SCL frequency
//   rst_n_i      asynchronous active-low reset
//   scl_i        SCL pin value (asynchronous)
//   sda_i        SDA pin value (asynchronous)
//   sda_t_o      SDA tristate control: 1 = release, 0 = drive low
//   reg_addr_o   register pointer
//   reg_wdata_o  write data, valid while reg_wr_o is high
//   reg_wr_o     one-cycle write strobe
//   reg_rd_o     one-cycle read strobe
//   reg_rdata_i  read data, sampled exactly one cycle after reg_rd_o
//   busy_o       high from an addressed START until STOP or a read NACK
//
// Register bus protocol: there is no back-pressure. reg_wr_o and reg_rd_o are
// single-cycle strobes, and at most one of them is high in any cycle.
// reg_addr_o (and reg_wdata_o for writes) is valid in the strobe cycle. After
// reg_rd_o, the register side must present reg_rdata_i in the very next
// cycle, where it is captured.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t state_q, state_d;

  // Input conditioning: two synchronizer stages, plus one registered copy
  // that is used for edge detection.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // START and STOP qualify only while SCL is steady high. SDA activity while
  // SCL is low is therefore never mistaken for bus conditions.
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  logic [2:0] bit_cnt_q;
  logic       byte_done_q;  // 8th bit sampled, waiting for its SCL fall
  logic [6:0] rx_sr_q;
  logic [7:0] tx_sr_q;
  logic       rw_q;
  logic       rd_dly_q;
  logic       pend_q, pend_val_q;
  logic [7:0] hold_cnt_q;

  logic       shifting, bit_rise, last_bit, addr_match;
  logic [7:0] rx_byte;

  assign shifting   = (state_q == S_ADDR) || (state_q == S_PTR) ||
                      (state_q == S_WDATA) || (state_q == S_RDATA);
  assign bit_rise   = scl_rise & shifting & ~start_det & ~stop_det;
  assign last_bit   = bit_rise & (bit_cnt_q == 3'd7);
  assign rx_byte    = {rx_sr_q, sda_s2};
  assign addr_match = (rx_byte[7:1] == DEV_ADDR);

  // FSM control signals.
  logic sched;       // schedule an SDA update HOLD_CYCLES from now
  logic sched_val;   // value to apply to sda_t_o
  logic tx_shift;    // advance the transmit shift register
  logic rd_pulse;    // request a register read strobe
  logic rd_advance;  // controller ACKed a read byte: move to the next address

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Byte-level sequencing. A data state counts bits on SCL rises. The SCL
  // fall after the 8th bit moves to the matching ACK state. The SCL fall that
  // ends the ACK clock moves to the next data state. Every SDA change is
  // requested on an SCL fall and applied after the hold delay.
  always_comb begin
    state_d    = state_q;
    sched      = 1'b0;
    sched_val  = 1'b1;
    tx_shift   = 1'b0;
    rd_pulse   = 1'b0;
    rd_advance = 1'b0;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (last_bit && !addr_match) begin
            state_d = S_WAIT;
          end else if (scl_fall && byte_done_q) begin
            state_d   = S_ADDR_ACK;
            sched     = 1'b1;
            sched_val = 1'b0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise && rw_q) rd_pulse = 1'b1;
          if (scl_fall) begin
            sched = 1'b1;
            if (rw_q) begin
              state_d   = S_RDATA;
              sched_val = tx_sr_q[7];
            end else begin
              state_d = S_PTR;
            end
          end
        end
        S_PTR: begin
          if (scl_fall && byte_done_q) begin
            state_d   = S_PTR_ACK;
            sched     = 1'b1;
            sched_val = 1'b0;
          end
        end
        S_PTR_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            sched   = 1'b1;
          end
        end
        S_WDATA: begin
          if (scl_fall && byte_done_q) begin
            state_d   = S_WDATA_ACK;
            sched     = 1'b1;
            sched_val = 1'b0;
          end
        end
        S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            sched   = 1'b1;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            sched = 1'b1;
            if (byte_done_q) begin
              state_d = S_RDATA_ACK;  // release SDA for the controller's ACK
            end else begin
              tx_shift  = 1'b1;
              sched_val = tx_sr_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              state_d = S_WAIT;       // NACK: the controller is done reading
            end else begin
              rd_pulse   = 1'b1;
              rd_advance = 1'b1;
            end
          end else if (scl_fall) begin
            state_d   = S_RDATA;
            sched     = 1'b1;
            sched_val = tx_sr_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  // SDA driver. A requested change waits HOLD_CYCLES. START or STOP releases
  // SDA at once and cancels any pending change.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sda_t_o    <= 1'b1;
      pend_q     <= 1'b0;
      pend_val_q <= 1'b1;
      hold_cnt_q <= 8'd0;
    end else if (start_det || stop_det) begin
      sda_t_o <= 1'b1;
      pend_q  <= 1'b0;
    end else if (sched) begin
      pend_q     <= 1'b1;
      pend_val_q <= sched_val;
      hold_cnt_q <= HOLD_INIT;
    end else if (pend_q) begin
      if (hold_cnt_q == 8'd0) begin
        sda_t_o <= pend_val_q;
        pend_q  <= 1'b0;
      end else begin
        hold_cnt_q <= hold_cnt_q - 8'd1;
      end
    end
  end

  // Bit counting, shift registers and the register-bus side.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 8'hFF;
      rw_q        <= 1'b0;
      rd_dly_q    <= 1'b0;
      reg_addr_o  <= 8'd0;
      reg_wdata_o <= 8'd0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      reg_wr_o <= 1'b0;
      reg_rd_o <= rd_pulse;
      rd_dly_q <= reg_rd_o;

      if (rd_dly_q)      tx_sr_q <= reg_rdata_i;
      else if (tx_shift) tx_sr_q <= {tx_sr_q[6:0], 1'b1};

      // A START or STOP in the middle of a byte throws away the partial byte.
      if (start_det || stop_det) begin
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
      end else if (bit_rise) begin
        rx_sr_q   <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
      end else if (scl_fall && byte_done_q) begin
        byte_done_q <= 1'b0;
      end

      if (last_bit && state_q == S_ADDR) rw_q <= rx_byte[0];

      if (last_bit && state_q == S_WDATA) begin
        reg_wdata_o <= rx_byte;
        reg_wr_o    <= 1'b1;
      end

      // The pointer moves on the cycle after a write strobe, or together
      // with the read strobe for the next byte of a read burst.
      if (last_bit && state_q == S_PTR) reg_addr_o <= rx_byte;
      else if (reg_wr_o || rd_advance)  reg_addr_o <= reg_addr_o + 8'd1;

      if (stop_det)
        busy_o <= 1'b0;
      else if (last_bit && state_q == S_ADDR)
        busy_o <= addr_match;
      else if (state_q == S_RDATA_ACK && state_d == S_WAIT)
        busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;

  localparam int Q    = 10;  // clk cycles per quarter SCL period
  localparam int HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       scl_c = 1'b1;
  logic       sda_c = 1'b1;
  logic       sda_t;
  logic       sda_line;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_wr, reg_rd, busy;

  // The line is a wired-AND of the controller and the target.
  assign sda_line = sda_c & sda_t;

  i2c_target_regs #(.DEV_ADDR(7'h48), .HOLD_CYCLES(HOLD)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .scl_i      (scl_c),
    .sda_i      (sda_line),
    .sda_t_o    (sda_t),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_wr_o   (reg_wr),
    .reg_rd_o   (reg_rd),
    .reg_rdata_i(reg_rdata),
    .busy_o     (busy)
  );

  // Register file: every register reads back as its address inverted, with
  // data valid in the cycle after the read strobe.
  always @(posedge clk) if (reg_rd) reg_rdata <= reg_addr ^ 8'hFF;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];     // expected writes {addr, data}
  logic [7:0]  rd_exp_q[$];  // expected read-strobe addresses
  logic [7:0]  m_ptr = 8'h00;  // reference register pointer

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int   wr_cnt = 0, rd_cnt = 0;
  int   sda_low_cnt = 0, busy_cnt = 0;
  logic watch = 1'b0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  logic [15:0] mon_w;
  logic [7:0]  mon_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (reg_wr) begin
        wr_cnt++;
        check("wr_single_cycle", prev_wr, 0);
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_w = exp_q.pop_front();
          check("wr_addr_data", {reg_addr, reg_wdata}, mon_w);
        end
      end
      if (reg_rd) begin
        rd_cnt++;
        check("rd_single_cycle", prev_rd, 0);
        if (rd_exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_r = rd_exp_q.pop_front();
          check("rd_addr", reg_addr, mon_r);
        end
      end
      if (reg_wr || reg_rd) check("one_strobe", reg_wr & reg_rd, 0);
      if (watch) begin
        if (!sda_t) sda_low_cnt++;
        if (busy)   busy_cnt++;
      end
      prev_wr = reg_wr;
      prev_rd = reg_rd;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_c = 1'b1; idle(Q);
    scl_c = 1'b1; idle(Q);
    sda_c = 1'b0; idle(Q);
    scl_c = 1'b0; idle(Q);
  endtask

  task automatic bus_stop;
    sda_c = 1'b0; idle(Q);
    scl_c = 1'b1; idle(Q);
    sda_c = 1'b1; idle(Q);
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_c = b;    idle(Q);
    scl_c = 1'b1; idle(Q);
    s = sda_line; idle(Q);
    scl_c = 1'b0; idle(Q);
  endtask

  // Sends one byte and returns the ACK seen, plus the number of cycles from
  // the SCL fall ending bit 8 until the target pulls SDA low (0 if never).
  task automatic write_byte(input logic [7:0] b, output logic ack, output int lat);
    logic s;
    lat = 0;
    for (int i = 7; i >= 0; i--) begin
      sda_c = b[i]; idle(Q);
      scl_c = 1'b1; idle(2 * Q);
      scl_c = 1'b0;
      if (i == 0) begin
        for (int k = 1; k <= Q; k++) begin
          @(negedge clk);
          if (lat == 0 && !sda_t) lat = k;
        end
      end else begin
        idle(Q);
      end
    end
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(~give_ack, s);
  endtask

  // SDA activity while SCL is low, including falling edges.
  task automatic glitch_low;
    for (int i = 0; i < 3; i++) begin
      sda_c = 1'b0; idle(2);
      sda_c = 1'b1; idle(2);
    end
  endtask

  task automatic txn_write(input logic [7:0] ptr, input int n,
                           input logic [7:0] data [4], input logic glitch);
    logic ack; int lat;
    bus_start;
    write_byte(8'h90, ack, lat);
    check("wr_addr_ack", ack, 1);
    check("wr_busy", busy, 1);
    write_byte(ptr, ack, lat);
    check("wr_ptr_ack", ack, 1);
    m_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      if (glitch) glitch_low;
      exp_q.push_back({m_ptr, data[i]});
      write_byte(data[i], ack, lat);
      check("wr_data_ack", ack, 1);
      m_ptr = m_ptr + 8'd1;
    end
    bus_stop; idle(4);
    check("wr_busy_stop", busy, 0);
  endtask

  task automatic txn_read(input logic [7:0] ptr, input int n, output logic [7:0] got [4]);
    logic ack; int lat; logic [7:0] d; logic [7:0] nxt;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    bus_start;
    write_byte(8'h90, ack, lat);
    check("rd_addr_ack", ack, 1);
    write_byte(ptr, ack, lat);
    check("rd_ptr_ack", ack, 1);
    m_ptr = ptr;
    bus_start;
    rd_exp_q.push_back(m_ptr);
    write_byte(8'h91, ack, lat);
    check("rd_addr2_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      nxt = m_ptr + 8'd1;
      if (i < n - 1) rd_exp_q.push_back(nxt);
      read_byte(i < n - 1, d);
      got[i] = d;
      check("rd_data", d, m_ptr ^ 8'hFF);
      if (i < n - 1) m_ptr = nxt;
    end
    check("rd_busy_nack", busy, 0);
    bus_stop; idle(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ack; int lat; logic s;
    logic [7:0] d;
    logic [7:0] buf4 [4];
    logic [7:0] got [4];
    int wr0, rd0, n, kind;
    logic [6:0] wa;

    idle(5);
    check("rst_sda_t", sda_t, 1);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_wr", reg_wr, 0);
    check("rst_rd", reg_rd, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);

    // Write burst, with SDA glitches while SCL is low before each data byte.
    bus_start;
    write_byte(8'h90, ack, lat);
    check("t1_addr_ack", ack, 1);
    check("t1_ack_latency", lat, 3 + HOLD);
    check("t1_busy", busy, 1);
    write_byte(8'h10, ack, lat);
    check("t1_ptr_ack", ack, 1);
    exp_q.push_back({8'h10, 8'hA5});
    glitch_low;
    write_byte(8'hA5, ack, lat);
    check("t1_d0_ack", ack, 1);
    exp_q.push_back({8'h11, 8'h5A});
    glitch_low;
    check("t1_busy_glitch", busy, 1);
    write_byte(8'h5A, ack, lat);
    check("t1_d1_ack", ack, 1);
    bus_stop; idle(4);
    check("t1_busy_stop", busy, 0);
    check("t1_writes_seen", exp_q.size(), 0);

    // Read burst with a repeated start, wrapping from 0xFF to 0x00.
    txn_read(8'hFE, 3, got);
    check("t2_b0", got[0], 8'h01);
    check("t2_b1", got[1], 8'h00);
    check("t2_b2", got[2], 8'hFF);

    // A different target address is never acknowledged.
    wr0 = wr_cnt; rd0 = rd_cnt;
    sda_low_cnt = 0; busy_cnt = 0; watch = 1'b1;
    bus_start;
    write_byte(8'h92, ack, lat);
    check("t3_nack", ack, 0);
    write_byte(8'h00, ack, lat);
    bus_stop; idle(4);
    watch = 1'b0;
    check("t3_sda_never_low", sda_low_cnt, 0);
    check("t3_busy_never", busy_cnt, 0);
    check("t3_no_wr", wr_cnt - wr0, 0);
    check("t3_no_rd", rd_cnt - rd0, 0);

    // A START after four data bits discards the partial byte.
    bus_start;
    write_byte(8'h90, ack, lat);
    write_byte(8'h40, ack, lat);
    m_ptr = 8'h40;
    for (int i = 0; i < 4; i++) send_bit(1'b1, s);
    wr0 = wr_cnt;
    buf4 = '{8'h33, 8'h00, 8'h00, 8'h00};
    txn_write(8'h20, 1, buf4, 1'b0);
    check("t4_one_write", wr_cnt - wr0, 1);
    check("t4_writes_seen", exp_q.size(), 0);

    // Reset while the target drives a 0 data bit.
    bus_start;
    write_byte(8'h90, ack, lat);
    write_byte(8'hFF, ack, lat);
    m_ptr = 8'hFF;
    bus_start;
    rd_exp_q.push_back(m_ptr);
    write_byte(8'h91, ack, lat);
    for (int k = 0; k < 2 * Q && sda_t; k++) @(negedge clk);
    check("t5_driving_zero", sda_t, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_sda_t", sda_t, 1);
    check("t5_rst_addr", reg_addr, 0);
    check("t5_rst_wdata", reg_wdata, 0);
    check("t5_rst_wr", reg_wr, 0);
    check("t5_rst_rd", reg_rd, 0);
    check("t5_rst_busy", busy, 0);
    m_ptr = 8'h00;
    scl_c = 1'b1; sda_c = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(5);
    bus_start;
    rd_exp_q.push_back(m_ptr);
    write_byte(8'h91, ack, lat);
    check("t5_addr_ack", ack, 1);
    read_byte(1'b0, d);
    check("t5_read_0", d, 8'hFF);
    check("t5_busy_nack", busy, 0);
    bus_stop; idle(4);

    // Random transactions.
    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) buf4[i] = 8'($urandom);
      if (kind == 0) begin
        txn_write(8'($urandom), n, buf4, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        txn_read(8'($urandom), n, got);
      end else begin
        wa = 7'($urandom_range(0, 127));
        if (wa == 7'h48) wa = 7'h49;
        wr0 = wr_cnt; rd0 = rd_cnt;
        sda_low_cnt = 0; watch = 1'b1;
        bus_start;
        write_byte({wa, 1'($urandom_range(0, 1))}, ack, lat);
        check("rnd_nack", ack, 0);
        write_byte(buf4[0], ack, lat);
        bus_stop; idle(4);
        watch = 1'b0;
        check("rnd_sda_quiet", sda_low_cnt, 0);
        check("rnd_no_strobe", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
      end
    end

    idle(10);
    check("final_wr_queue", exp_q.size(), 0);
    check("final_rd_queue", rd_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) giving an external I2C controller byte-wide access to a 256-entry register space through a simple strobe bus. It is the far end of the I2C buses the TURF drives from the PS EMIO controller, used on boards hanging off the CLK/CAL/TURFIO I2C segments. SCL/SDA are oversampled in `clk_i`; the block never stretches SCL and drives SDA open-drain only.

## Interface
- `DEV_ADDR`, 7'h48, 7-bit target address answered.
- `HOLD_CYCLES`, 4, `clk_i` cycles between detected SCL fall and any SDA change.
- `clk_i`  in  1  block clock, ≥20× SCL frequency.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `scl_i`  in  1  SCL pin value (async).
- `sda_i`  in  1  SDA pin value (async).
- `sda_t_o`  out  1  SDA tristate: 1 = release, 0 = drive low.
- `reg_addr_o`  out  8  register pointer.
- `reg_wdata_o`  out  8  write data, valid with `reg_wr_o`.
- `reg_wr_o`  out  1  one-cycle write strobe.
- `reg_rd_o`  out  1  one-cycle read strobe.
- `reg_rdata_i`  in  8  read data, sampled exactly 1 cycle after `reg_rd_o`.
- `busy_o`  out  1  high from addressed START to STOP/NACK-end.

## Operation
- Input conditioning: 2-FF synchronizers on SCL and SDA, then 1-cycle registered copy for edge detect.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both are honoured in every state; START → ADDR, STOP → IDLE. START has priority over any in-progress bit.
- Data bits sampled on synced SCL rising edge, MSB first; 3-bit bit counter.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- ADDR: 8 bits shifted. Upper 7 == `DEV_ADDR` → ADDR_ACK, `busy_o`=1; else → WAIT (no ACK, SDA released).
- ADDR_ACK: R/W=0 → PTR; R/W=1 → RDATA; `reg_rd_o` pulsed on ACK-clock SCL rise, `reg_rdata_i` loaded into TX shift register next cycle.
- PTR: first write byte loads `reg_addr_o`; ACK; → WDATA.
- WDATA: after 8th bit, `reg_wdata_o` = byte and `reg_wr_o` pulses with current `reg_addr_o`; following cycle `reg_addr_o` increments (8-bit, 0xFF wraps to 0x00); ACK; stays in WDATA.
- RDATA: TX bits driven (0 → drive, 1 → release). At RDATA_ACK, SDA released and controller ACK sampled on SCL rise: ACK → `reg_addr_o`++, `reg_rd_o` pulse at new address, reload, → RDATA; NACK → WAIT, `busy_o`=0.
- Repeated START keeps `reg_addr_o`, so write-pointer-then-read works.
- WAIT: SDA released; exits only on START/STOP.

## Timing
- Reset values: `sda_t_o`=1, `reg_addr_o`=0, `reg_wdata_o`=0, `reg_wr_o`=0, `reg_rd_o`=0, `busy_o`=0, state IDLE. Reset mid-transaction releases SDA asynchronously.
- Pin → internal event latency: 3 `clk_i` cycles.
- ACK drive: `sda_t_o`→0 `HOLD_CYCLES` after the SCL fall ending bit 8; →1 `HOLD_CYCLES` after the SCL fall ending the ACK clock.
- TX bit n+1 presented `HOLD_CYCLES` after SCL fall of bit n (first bit after ADDR_ACK/RDATA_ACK fall).
- `reg_wr_o`: 1 cycle after the 8th data-bit SCL-rise detection. `reg_rd_o`: 1 cycle after ACK-clock SCL-rise detection; data captured next cycle, well before TX needs it.
- START/STOP during ACK or data drive: `sda_t_o`=1 same cycle as detection.
- Never more than one strobe per cycle; strobes are single-cycle.

## Test plan
- Write: S, 0x90, 0x10, 0xA5, 0x5A, P → two ACKs+data ACKs; `reg_wr_o` with (0x10,0xA5) then (0x11,0x5A); `busy_o` drops on P.
- Read with repeated start: S 0x90 0xFE Sr 0x91, read 3 bytes ACK,ACK,NACK, P with regs returning addr^0xFF → bytes 0x01,0x00,0xFF from addresses 0xFE,0xFF,0x00 (wrap).
- Wrong address S 0x92 … P → `sda_t_o` stays 1 throughout, no strobes, `busy_o`=0.
- START injected mid WDATA byte (after bit 4) then 0x90 0x20 0x33 → partial byte discarded, one write (0x20,0x33).
- `rst_n_i` low during read-data drive of a 0 bit → `sda_t_o`=1 immediately, all outputs at reset values; next S 0x91 reads from address 0x00.
- SDA glitch while SCL low and START-like SDA fall while SCL low → no START/STOP detected, state unchanged.
